// File: rtl/ysyx_25020047_mem_arbiter.sv
// ysyx_25020047_mem_arbiter: shares one memory port between the IFU (read-only)
// and the LSU (read/write with byte mask). One transaction in flight at a time.
// Optional feature: define YSYX_ARB_RR_EN for round-robin arbitration on ties;
// without it the LSU always wins over the IFU.
module ysyx_25020047_mem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_req_addr,
   output logic                ifu_resp_valid,
   output logic [DATA_W-1:0]   ifu_resp_data,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic                lsu_req_wen,
   input  logic [ADDR_W-1:0]   lsu_req_addr,
   input  logic [DATA_W-1:0]   lsu_req_wdata,
   input  logic [DATA_W/8-1:0] lsu_req_wmask,
   output logic                lsu_resp_valid,
   output logic [DATA_W-1:0]   lsu_resp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic                mem_req_wen,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data
);

   localparam int unsigned MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e              state_q;
   logic                owner_lsu_q;
   logic                mem_req_valid_q;
   logic                mem_req_wen_q;
   logic [ADDR_W-1:0]   mem_req_addr_q;
   logic [DATA_W-1:0]   mem_req_wdata_q;
   logic [MASK_W-1:0]   mem_req_wmask_q;
   logic                ifu_resp_valid_q;
   logic [DATA_W-1:0]   ifu_resp_data_q;
   logic                lsu_resp_valid_q;
   logic [DATA_W-1:0]   lsu_resp_data_q;

   logic                lsu_wins;
   logic                grant_lsu;
   logic                grant_ifu;

`ifdef YSYX_ARB_RR_EN
   logic                last_lsu_q;

   // On a tie the LSU wins only if the IFU was granted last
   assign lsu_wins = !ifu_req_valid || !last_lsu_q;

   // Round-robin pointer: remembers which requester got the most recent grant
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_lsu_q <= 1'b0;
      end else if (grant_lsu) begin
         last_lsu_q <= 1'b1;
      end else if (grant_ifu) begin
         last_lsu_q <= 1'b0;
      end
   end
`else
   assign lsu_wins = 1'b1;
`endif

   // Grant decision; ready is combinational so the handshake completes in IDLE
   always_comb begin
      grant_lsu = 1'b0;
      grant_ifu = 1'b0;
      if ((state_q == S_IDLE) && !reset) begin
         grant_lsu = lsu_req_valid && lsu_wins;
         grant_ifu = ifu_req_valid && !grant_lsu;
      end
   end

   assign ifu_req_ready  = grant_ifu;
   assign lsu_req_ready  = grant_lsu;
   assign mem_req_valid  = mem_req_valid_q;
   assign mem_req_wen    = mem_req_wen_q;
   assign mem_req_addr   = mem_req_addr_q;
   assign mem_req_wdata  = mem_req_wdata_q;
   assign mem_req_wmask  = mem_req_wmask_q;
   assign ifu_resp_valid = ifu_resp_valid_q;
   assign ifu_resp_data  = ifu_resp_data_q;
   assign lsu_resp_valid = lsu_resp_valid_q;
   assign lsu_resp_data  = lsu_resp_data_q;

   // Transaction FSM: latch request, hold it to memory, route the response back
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= S_IDLE;
         owner_lsu_q      <= 1'b0;
         mem_req_valid_q  <= 1'b0;
         mem_req_wen_q    <= 1'b0;
         mem_req_addr_q   <= '0;
         mem_req_wdata_q  <= '0;
         mem_req_wmask_q  <= '0;
         ifu_resp_valid_q <= 1'b0;
         ifu_resp_data_q  <= '0;
         lsu_resp_valid_q <= 1'b0;
         lsu_resp_data_q  <= '0;
      end else begin
         ifu_resp_valid_q <= 1'b0;
         lsu_resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_lsu) begin
                  owner_lsu_q     <= 1'b1;
                  mem_req_wen_q   <= lsu_req_wen;
                  mem_req_addr_q  <= lsu_req_addr;
                  mem_req_wdata_q <= lsu_req_wdata;
                  mem_req_wmask_q <= lsu_req_wmask;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= S_REQ;
               end else if (grant_ifu) begin
                  owner_lsu_q     <= 1'b0;
                  mem_req_wen_q   <= 1'b0;
                  mem_req_addr_q  <= ifu_req_addr;
                  mem_req_wdata_q <= '0;
                  mem_req_wmask_q <= '0;
                  mem_req_valid_q <= 1'b1;
                  state_q         <= S_REQ;
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid_q <= 1'b0;
                  state_q         <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  if (owner_lsu_q) begin
                     lsu_resp_valid_q <= 1'b1;
                     lsu_resp_data_q  <= mem_resp_data;
                  end else begin
                     ifu_resp_valid_q <= 1'b1;
                     ifu_resp_data_q  <= mem_resp_data;
                  end
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// Self-checking bench for ysyx_25020047_mem_arbiter: directed scenarios followed
// by a randomized run against a transaction-level model with a word memory.
module tb_ysyx_25020047_mem_arbiter;

`ifdef YSYX_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        ifu_v, ifu_rdy, ifu_rv;
   logic [31:0] ifu_a, ifu_rd;
   logic        lsu_v, lsu_rdy, lsu_wen, lsu_rv;
   logic [31:0] lsu_a, lsu_wd, lsu_rd;
   logic [3:0]  lsu_wm;
   logic        m_v, m_rdy, m_wen, m_rv;
   logic [31:0] m_a, m_wd, m_rd;
   logic [3:0]  m_wm;

   int n_pass = 0, n_fail = 0, n_total = 0;
   int cyc = 0;
   bit          last_lsu_m;               // model: last grant went to LSU
   logic [31:0] exp_ifu_data, exp_lsu_data;
   logic [31:0] mem_m [16];

   ysyx_25020047_mem_arbiter dut (
      .clock(clock), .reset(reset),
      .ifu_req_valid(ifu_v), .ifu_req_ready(ifu_rdy), .ifu_req_addr(ifu_a),
      .ifu_resp_valid(ifu_rv), .ifu_resp_data(ifu_rd),
      .lsu_req_valid(lsu_v), .lsu_req_ready(lsu_rdy), .lsu_req_wen(lsu_wen),
      .lsu_req_addr(lsu_a), .lsu_req_wdata(lsu_wd), .lsu_req_wmask(lsu_wm),
      .lsu_resp_valid(lsu_rv), .lsu_resp_data(lsu_rd),
      .mem_req_valid(m_v), .mem_req_ready(m_rdy), .mem_req_wen(m_wen),
      .mem_req_addr(m_a), .mem_req_wdata(m_wd), .mem_req_wmask(m_wm),
      .mem_resp_valid(m_rv), .mem_resp_data(m_rd)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_fields(input string tag, input logic wen, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] wm);
      chk(tag, 96'({m_wen, m_a, m_wd, m_wm}), 96'({wen, addr, wd, wm}));
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, ".ifu_rv"}, 96'(ifu_rv), 96'(0));
      chk({tag, ".lsu_rv"}, 96'(lsu_rv), 96'(0));
      chk({tag, ".ifu_rd_hold"}, 96'(ifu_rd), 96'(exp_ifu_data));
      chk({tag, ".lsu_rd_hold"}, 96'(lsu_rd), 96'(exp_lsu_data));
   endtask

   // Check a response pulse for the given owner and update held-data expectations
   task automatic chk_resp(input string tag, input bit lsu, input logic [31:0] data);
      if (lsu) exp_lsu_data = data;
      else     exp_ifu_data = data;
      chk({tag, ".ifu_rv"}, 96'(ifu_rv), 96'(!lsu));
      chk({tag, ".lsu_rv"}, 96'(lsu_rv), 96'(lsu));
      chk({tag, ".ifu_rd"}, 96'(ifu_rd), 96'(exp_ifu_data));
      chk({tag, ".lsu_rd"}, 96'(lsu_rd), 96'(exp_lsu_data));
   endtask

   // One single-requester transaction with mem stall and response delay
   task automatic single_txn(input string tag, input bit lsu, input bit wen,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wmask, input int stall, input int rdly,
                             input logic [31:0] rdata);
      int t0;
      logic        ewen;
      logic [31:0] ewd;
      logic [3:0]  ewm;
      ewen = lsu ? wen : 1'b0;
      ewd  = lsu ? wdata : 32'h0;
      ewm  = lsu ? wmask : 4'h0;
      if (lsu) begin
         lsu_v = 1'b1; lsu_wen = wen; lsu_a = addr; lsu_wd = wdata; lsu_wm = wmask;
      end else begin
         ifu_v = 1'b1; ifu_a = addr;
      end
      #1;
      chk({tag, ".ready"}, 96'(lsu ? lsu_rdy : ifu_rdy), 96'(1));
      chk({tag, ".other_ready"}, 96'(lsu ? ifu_rdy : lsu_rdy), 96'(0));
      last_lsu_m = lsu;
      t0 = cyc;
      next();
      for (int i = 0; i < stall; i++) begin
         ifu_v = 1'b1; lsu_v = 1'b1; ifu_a = $urandom; lsu_a = $urandom; lsu_wd = $urandom;
         m_rdy = 1'b0; m_rv = (i == 0); m_rd = $urandom;
         #1;
         chk({tag, ".stall_mvalid"}, 96'(m_v), 96'(1));
         chk_fields({tag, ".stall_fields"}, ewen, addr, ewd, ewm);
         chk({tag, ".stall_readies"}, 96'({ifu_rdy, lsu_rdy}), 96'(0));
         next();
      end
      ifu_v = 1'b0; lsu_v = 1'b0; m_rv = 1'b0; m_rdy = 1'b1;
      chk({tag, ".mvalid"}, 96'(m_v), 96'(1));
      chk_fields({tag, ".fields"}, ewen, addr, ewd, ewm);
      chk_quiet({tag, ".req"});
      next();
      m_rdy = 1'b0;
      chk({tag, ".wait_mvalid"}, 96'(m_v), 96'(0));
      for (int i = 0; i < rdly; i++) begin
         chk_quiet({tag, ".wait"});
         next();
      end
      m_rv = 1'b1; m_rd = rdata;
      next();
      m_rv = 1'b0; m_rd = $urandom;
      chk_resp({tag, ".resp"}, lsu, rdata);
      chk({tag, ".latency"}, 96'(cyc - t0), 96'(3 + stall + rdly));
      next();
      chk_quiet({tag, ".after"});
   endtask

   // Random run state (transaction-level view of one outstanding request)
   int          phase;     // 0 none, 1 granted, 2 accepted by memory, 3 response sent
   int          dly, idx;
   bit          was_req, exp_l, exp_i, got;
   bit          cur_lsu, cur_wen;
   logic [31:0] cur_addr, cur_wd, sent_data, bm;
   logic [3:0]  cur_wm;
   int          cur_idx;

   initial begin
      reset = 1'b1;
      ifu_v = 1'b1; ifu_a = 32'h0; lsu_v = 1'b1; lsu_wen = 1'b0; lsu_a = 32'h0;
      lsu_wd = 32'h0; lsu_wm = 4'h0; m_rdy = 1'b0; m_rv = 1'b0; m_rd = 32'h0;
      last_lsu_m = 1'b0; exp_ifu_data = 32'h0; exp_lsu_data = 32'h0;
      for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
      repeat (2) @(posedge clock);
      #1;
      chk("reset.readies", 96'({ifu_rdy, lsu_rdy}), 96'(0));
      chk("reset.mvalid", 96'(m_v), 96'(0));
      chk_fields("reset.fields", 1'b0, 32'h0, 32'h0, 4'h0);
      chk_quiet("reset");
      ifu_v = 1'b0; lsu_v = 1'b0;
      reset = 1'b0;
      next();

      // Stray memory response while idle is dropped
      m_rv = 1'b1; m_rd = 32'h1234_5678;
      next();
      m_rv = 1'b0;
      chk_quiet("idle_stray");

      single_txn("ifu_rd", 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF);
      single_txn("lsu_st", 1'b1, 1'b1, 32'h8000_0104, 32'h0000_AB00, 4'h2, 0, 1, $urandom);
      single_txn("stall5", 1'b0, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 5, 0, 32'hCAFE_F00D);

      // Reset while waiting for the memory response abandons the transaction
      ifu_v = 1'b1; ifu_a = 32'h8000_0080;
      next();
      ifu_v = 1'b0; m_rdy = 1'b1;
      next();
      m_rdy = 1'b0; ifu_v = 1'b1; reset = 1'b1;
      #1;
      exp_ifu_data = 32'h0; exp_lsu_data = 32'h0; last_lsu_m = 1'b0;
      chk("rst_wait.readies", 96'({ifu_rdy, lsu_rdy}), 96'(0));
      chk("rst_wait.mvalid", 96'(m_v), 96'(0));
      chk_fields("rst_wait.fields", 1'b0, 32'h0, 32'h0, 4'h0);
      chk_quiet("rst_wait");
      next();
      reset = 1'b0; ifu_v = 1'b0; m_rv = 1'b1; m_rd = 32'hBAD0_BAD0;
      next();
      m_rv = 1'b0;
      chk_quiet("rst_wait.stray");
      next();
      chk_quiet("rst_wait.stray2");
      single_txn("post_rst", 1'b0, 1'b0, 32'h8000_0200, 32'h0, 4'h0, 0, 0, 32'h0BAD_CAFE);

      // Both requesters valid every cycle for four transactions
      ifu_v = 1'b1; lsu_v = 1'b1; lsu_wen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ifu_a = $urandom; lsu_a = $urandom;
         got = 1'b0;
         for (int w = 0; w < 6 && !got; w++) begin
            #1;
            if (ifu_rdy || lsu_rdy) got = 1'b1;
            else next();
         end
         chk("arb.grant_seen", 96'(got), 96'(1));
         exp_l = RR ? !last_lsu_m : 1'b1;
         chk("arb.lsu_ready", 96'(lsu_rdy), 96'(exp_l));
         chk("arb.ifu_ready", 96'(ifu_rdy), 96'(!exp_l));
         last_lsu_m = exp_l;
         next();
         m_rdy = 1'b1;
         next();
         m_rdy = 1'b0; m_rv = 1'b1; sent_data = $urandom; m_rd = sent_data;
         next();
         m_rv = 1'b0;
         chk_resp("arb.resp", exp_l, sent_data);
      end
      ifu_v = 1'b0; lsu_v = 1'b0;
      next();

      // Randomized traffic against the transaction-level model
      phase = 0;
      for (int c = 0; c < 420; c++) begin
         if (phase == 3) begin
            chk_resp("rnd.resp", cur_lsu, sent_data);
            phase = 0;
         end else begin
            chk_quiet("rnd.quiet");
         end
         was_req = (phase == 1);
         chk("rnd.mvalid", 96'(m_v), 96'(was_req));
         if (was_req) chk_fields("rnd.fields", cur_wen, cur_addr, cur_wd, cur_wm);
         m_rdy = (c >= 400) ? 1'b1 : ($urandom_range(0, 2) != 0);
         m_rv = 1'b0; m_rd = $urandom;
         if (phase == 2) begin
            if (dly == 0) begin
               m_rv = 1'b1;
               sent_data = (cur_lsu && cur_wen) ? 32'($urandom) : mem_m[cur_idx];
               m_rd = sent_data;
               phase = 3;
            end else begin
               dly--;
            end
         end else if (phase <= 1) begin
            m_rv = ($urandom_range(0, 5) == 0);
         end
         ifu_v = (c < 400) && ($urandom_range(0, 1) == 1);
         lsu_v = (c < 400) && ($urandom_range(0, 1) == 1);
         idx = $urandom_range(0, 15);
         ifu_a = 32'h8000_0000 + 32'(idx) * 32'd4;
         idx = $urandom_range(0, 15);
         lsu_a = 32'h8000_0000 + 32'(idx) * 32'd4;
         lsu_wen = $urandom_range(0, 1) == 1;
         lsu_wd = $urandom; lsu_wm = 4'($urandom);
         #1;
         exp_l = 1'b0; exp_i = 1'b0;
         if (phase == 0) begin
            exp_l = lsu_v && (!ifu_v || !RR || !last_lsu_m);
            exp_i = ifu_v && !exp_l;
         end
         chk("rnd.lsu_ready", 96'(lsu_rdy), 96'(exp_l));
         chk("rnd.ifu_ready", 96'(ifu_rdy), 96'(exp_i));
         if (exp_l || exp_i) begin
            cur_lsu = exp_l; last_lsu_m = exp_l;
            cur_wen  = exp_l ? lsu_wen : 1'b0;
            cur_addr = exp_l ? lsu_a : ifu_a;
            cur_wd   = exp_l ? lsu_wd : 32'h0;
            cur_wm   = exp_l ? lsu_wm : 4'h0;
            cur_idx  = int'((cur_addr - 32'h8000_0000) >> 2);
            phase = 1;
         end
         if (was_req && m_rdy) begin
            phase = 2;
            dly = $urandom_range(0, 3);
            if (cur_wen) begin
               for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{cur_wm[b]}};
               mem_m[cur_idx] = (mem_m[cur_idx] & ~bm) | (cur_wd & bm);
            end
         end
         next();
      end
      chk("rnd.drained", 96'(phase), 96'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ysyx_25020047_mem_arbiter.md
# ysyx_25020047_mem_arbiter

Shares the core's single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write with byte mask). Accepts one request at a time, sequences it through a request/response handshake with the memory side, and routes the response back to the originating requester. It sits between IFU/LSU and the memory bridge in the NPC top level.

## Interface

- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width; mask width is DATA_W/8

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_req_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  one-cycle pulse, IFU read data valid
- ifu_resp_data  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_addr  in  ADDR_W  LSU address
- lsu_req_wdata  in  DATA_W  store data, already lane-aligned
- lsu_req_wmask  in  DATA_W/8  store byte enables
- lsu_resp_valid  out  1  one-cycle pulse, LSU load data / store ack
- lsu_resp_data  out  DATA_W  load data (store: forwarded mem_resp_data, don't-care)
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- mem_resp_valid  in  1  memory response
- mem_resp_data  in  DATA_W  memory read data

## Operation

- FSM states: IDLE, REQ, WAIT.
- IDLE: if any req_valid, grant one (see Configuration); assert that requester's req_ready combinationally in the same cycle; latch addr/wen/wdata/wmask and owner; next state REQ. IFU grants latch wen=0, wmask=0, wdata=0.
- REQ: mem_req_valid=1 with latched fields held stable; on mem_req_ready=1 go WAIT. mem_resp_valid in REQ is ignored.
- WAIT: on mem_resp_valid=1, register mem_resp_data into owner's resp_data, pulse owner's resp_valid next cycle, go IDLE.
- req_ready is never asserted outside IDLE; at most one req_ready high per cycle.
- Requesters must accept resp_valid unconditionally (no resp back-pressure).
- mem_resp_valid in IDLE is dropped silently.
- Non-owner resp_valid stays 0; non-owner resp_data holds its previous value.

## Timing

- Reset values: all req_ready, resp_valid, mem_req_valid = 0; resp_data, mem_req_* fields = 0; state IDLE; round-robin pointer = IFU (LSU wins first tie).
- Handshake at cycle T (IDLE) → mem_req_valid from T+1; if mem_req_ready at T+1, WAIT at T+2; earliest mem_resp_valid counted at T+2; resp_valid at T+3. Minimum request-to-response latency 3 cycles.
- FSM returns to IDLE in the same cycle resp_valid is high, so a new grant may occur that cycle (back-to-back throughput: one transaction per 3 cycles minimum).
- mem_req_ready stall of N cycles adds N cycles; mem_resp_valid delay adds equally.
- Reset asserted mid-transaction: immediate return to reset values; in-flight transaction abandoned, no response delivered; subsequent stray mem_resp_valid dropped.

## Configuration

- YSYX_ARB_RR_EN defined: round-robin. On simultaneous valid, grant the requester not granted last; pointer updates on every grant.
- Not defined: fixed priority, LSU always wins over IFU; pointer register absent.
- Single-requester behaviour identical in both builds.

## Test plan

- Reset then IFU read addr 0x8000_0000, mem ready immediately, resp 0xDEAD_BEEF after 1 cycle → ifu_req_ready at T, mem_req_valid T+1, ifu_resp_valid pulse at T+3 with 0xDEAD_BEEF, lsu_resp_valid stays 0.
- LSU store addr 0x8000_0104, wdata 0x0000_AB00, wmask 0x2 → mem_req_wen=1, wmask=0x2, wdata/addr forwarded exactly; lsu_resp_valid one-cycle pulse.
- IFU and LSU valid every cycle for 4 transactions → RR build grants LSU, IFU, LSU, IFU; fixed build grants LSU four times, IFU ready never high.
- mem_req_ready held low 5 cycles → mem_req_* fields stable, no req_ready asserted, response latency 8 cycles.
- Reset pulse while in WAIT, then mem_resp_valid → no resp_valid on either requester; next IFU request completes normally.
- mem_resp_valid pulsed while IDLE and in REQ → ignored, no resp_valid.
